// File: rtl/event_timestamp_fifo.sv
// Timestamping FWFT event FIFO with valid/ready readout.
// Entries are {last, ts, event}; overflow is sticky with a saturating drop count.
module event_timestamp_fifo #(
  parameter int WIDTH    = 10,
  parameter int TS_WIDTH = 16,
  parameter int DEPTH    = 8,
  parameter int DROP_W   = 8
) (
  input  logic                        clk_i,
  input  logic                        reset_i,
  input  logic                        evt_valid_i,
  input  logic [WIDTH-1:0]            evt_data_i,
  input  logic                        grp_release_i,
  input  logic                        out_ready_i,
  output logic                        out_valid_o,
  output logic [WIDTH+TS_WIDTH:0]     out_data_o,
  output logic [$clog2(DEPTH):0]      level_o,
  output logic                        overflow_o,
  output logic [DROP_W-1:0]           drop_cnt_o,
  input  logic                        clr_ovf_i
);

  localparam int AW = $clog2(DEPTH);
  localparam int DW = WIDTH + TS_WIDTH + 1;
  localparam logic [AW:0] LP_FULL = (AW+1)'(DEPTH);

  logic [TS_WIDTH-1:0] r_ts;
  logic [AW-1:0]       r_wr_ptr;
  logic [AW-1:0]       r_rd_ptr;
  logic [AW:0]         r_count;
  logic                r_ovf;
  logic [DROP_W-1:0]   r_drop_cnt;
  logic [DW-1:0]       r_mem [DEPTH];

  logic                w_full;
  logic                w_empty;
  logic                w_push;
  logic                w_pop;
  logic                w_drop;
  logic [AW:0]         w_count_nxt;
  logic [DROP_W-1:0]   w_drop_inc;

  // Full/empty come from the occupancy count, never from pointer compare
  assign w_full  = (r_count == LP_FULL);
  assign w_empty = (r_count == '0);
  assign w_pop   = !w_empty && out_ready_i;
  assign w_push  = evt_valid_i && (!w_full || w_pop);
  assign w_drop  = evt_valid_i && w_full && !w_pop;

  always_comb begin
    w_count_nxt = r_count;
    unique case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + (AW+1)'(1);
      2'b01:   w_count_nxt = r_count - (AW+1)'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  assign w_drop_inc = (r_drop_cnt == '1) ? r_drop_cnt
                                         : r_drop_cnt + DROP_W'(1);

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ts     <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      r_ts    <= r_ts + TS_WIDTH'(1);
      r_count <= w_count_nxt;
      if (w_push)
        r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)
        r_rd_ptr <= r_rd_ptr + AW'(1);
    end
  end

  // A drop in the same cycle as a clear restarts the count at one
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end else if (w_drop) begin
      r_ovf      <= 1'b1;
      r_drop_cnt <= clr_ovf_i ? DROP_W'(1) : w_drop_inc;
    end else if (clr_ovf_i) begin
      r_ovf      <= 1'b0;
      r_drop_cnt <= '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push)
      r_mem[r_wr_ptr] <= {grp_release_i, r_ts, evt_data_i};
  end

  assign out_valid_o = !w_empty;
  assign out_data_o  = r_mem[r_rd_ptr];
  assign level_o     = r_count;
  assign overflow_o  = r_ovf;
  assign drop_cnt_o  = r_drop_cnt;

endmodule

// File: tb/tb_event_timestamp_fifo.sv
// Bench for event_timestamp_fifo: queue model checked every cycle,
// directed scenarios plus a random phase.
module tb_event_timestamp_fifo;

  logic        clk_i = 1'b0;
  logic        reset_i = 1'b1;
  logic        evt_valid_i = 1'b0;
  logic [9:0]  evt_data_i = '0;
  logic        grp_release_i = 1'b0;
  logic        out_ready_i = 1'b0;
  logic        out_valid_o;
  logic [26:0] out_data_o;
  logic [3:0]  level_o;
  logic        overflow_o;
  logic [7:0]  drop_cnt_o;
  logic        clr_ovf_i = 1'b0;

  event_timestamp_fifo dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .evt_valid_i   (evt_valid_i),
    .evt_data_i    (evt_data_i),
    .grp_release_i (grp_release_i),
    .out_ready_i   (out_ready_i),
    .out_valid_o   (out_valid_o),
    .out_data_o    (out_data_o),
    .level_o       (level_o),
    .overflow_o    (overflow_o),
    .drop_cnt_o    (drop_cnt_o),
    .clr_ovf_i     (clr_ovf_i)
  );

  always #5 clk_i = ~clk_i;

  int          n_vec = 0;
  int          n_err = 0;
  logic [26:0] m_q[$];
  logic [15:0] m_ts;
  logic        m_ovf;
  logic [7:0]  m_drop;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called mid-cycle; reset asserts and releases between two edges
  task automatic do_reset();
    reset_i = 1'b1;
    evt_valid_i = 1'b0;
    out_ready_i = 1'b0;
    clr_ovf_i = 1'b0;
    #1;
    chk("rst_valid", 32'(out_valid_o), 32'd0);
    chk("rst_level", 32'(level_o), 32'd0);
    chk("rst_ovf", 32'(overflow_o), 32'd0);
    chk("rst_drop", 32'(drop_cnt_o), 32'd0);
    #1;
    reset_i = 1'b0;
    m_q.delete();
    m_ts = '0;
    m_ovf = 1'b0;
    m_drop = '0;
    #1;
  endtask

  task automatic step(input logic v, input logic [9:0] d, input logic g,
                      input logic r, input logic c);
    int   sz;
    logic full, pop, push, drop;
    evt_valid_i = v;
    evt_data_i = d;
    grp_release_i = g;
    out_ready_i = r;
    clr_ovf_i = c;
    sz = m_q.size();
    chk("valid", 32'(out_valid_o), 32'(sz != 0));
    if (sz != 0)
      chk("head", 32'(out_data_o), 32'(m_q[0]));
    chk("level", 32'(level_o), sz);
    chk("ovf", 32'(overflow_o), 32'(m_ovf));
    chk("dropcnt", 32'(drop_cnt_o), 32'(m_drop));
    full = (sz == 8);
    pop  = (sz != 0) && r;
    push = v && (!full || pop);
    drop = v && full && !pop;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back({g, m_ts, d});
    if (drop) begin
      m_ovf = 1'b1;
      m_drop = c ? 8'd1 : ((m_drop == 8'hFF) ? 8'hFF : m_drop + 8'd1);
    end else if (c) begin
      m_ovf = 1'b0;
      m_drop = '0;
    end
    m_ts = m_ts + 16'd1;
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    step(1'b0, 10'd0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    logic [15:0] t0;
    logic [15:0] tprev;
    #1;
    do_reset();
    idle();

    // single event, one-cycle latency
    t0 = m_ts;
    step(1'b1, 10'h2A5, 1'b0, 1'b1, 1'b0);
    chk("t1_valid", 32'(out_valid_o), 32'd1);
    chk("t1_data", 32'(out_data_o), 32'({1'b0, t0, 10'h2A5}));
    step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
    chk("t1_level", 32'(level_o), 32'd0);

    // fill, overflow by one, drain in order
    for (int i = 1; i <= 8; i++)
      step(1'b1, 10'(i), 1'b0, 1'b0, 1'b0);
    chk("t2_full", 32'(level_o), 32'd8);
    chk("t2_noovf", 32'(overflow_o), 32'd0);
    step(1'b1, 10'h009, 1'b1, 1'b0, 1'b0);
    chk("t2_ovf", 32'(overflow_o), 32'd1);
    chk("t2_drop", 32'(drop_cnt_o), 32'd1);
    tprev = '0;
    for (int i = 1; i <= 8; i++) begin
      chk("t2_order", 32'(out_data_o[9:0]), 32'(i));
      if (i > 1)
        chk("t2_ts", 32'(out_data_o[25:10]), 32'(tprev + 16'd1));
      tprev = out_data_o[25:10];
      step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
    end
    chk("t2_empty", 32'(level_o), 32'd0);

    // full with simultaneous push and pop
    for (int i = 0; i < 8; i++)
      step(1'b1, 10'(16 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 10'h3FF, 1'b1, 1'b1, 1'b0);
    chk("t3_level", 32'(level_o), 32'd8);
    chk("t3_head", 32'(out_data_o[9:0]), 32'd17);
    chk("t3_drop", 32'(drop_cnt_o), 32'd1);

    // saturating drop counter and clear priority
    for (int i = 0; i < 300; i++)
      step(1'b1, 10'(i), 1'b0, 1'b0, 1'b0);
    chk("t4_sat", 32'(drop_cnt_o), 32'd255);
    step(1'b0, 10'd0, 1'b0, 1'b0, 1'b1);
    chk("t4_clr_ovf", 32'(overflow_o), 32'd0);
    chk("t4_clr_cnt", 32'(drop_cnt_o), 32'd0);
    step(1'b1, 10'h155, 1'b0, 1'b0, 1'b1);
    chk("t4_win_ovf", 32'(overflow_o), 32'd1);
    chk("t4_win_cnt", 32'(drop_cnt_o), 32'd1);

    // random traffic
    for (int i = 0; i < 600; i++)
      step(1'($urandom_range(0, 1)), 10'($urandom_range(0, 1023)),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0));

    // async reset with three entries queued
    for (int i = 0; i < 20; i++)
      step(1'b0, 10'd0, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 3; i++)
      step(1'b1, 10'(100 + i), 1'b0, 1'b0, 1'b0);
    chk("t6_pre", 32'(level_o), 32'd3);
    do_reset();
    idle();
    chk("t6_stale", 32'(out_valid_o), 32'd0);
    do_reset();
    step(1'b1, 10'h0AA, 1'b0, 1'b0, 1'b0);
    chk("t6_ts0", 32'(out_data_o[25:10]), 32'd0);
    step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);

    // timestamp wrap
    do_reset();
    for (int k = 0; k < 65540; k++)
      step((k == 65535) || (k == 65537), 10'(k), 1'b0, 1'b0, 1'b0);
    chk("t5_level", 32'(level_o), 32'd2);
    chk("t5_ts_ffff", 32'(out_data_o[25:10]), 32'h0000FFFF);
    step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
    chk("t5_ts_0001", 32'(out_data_o[25:10]), 32'h00000001);
    step(1'b0, 10'd0, 1'b0, 1'b1, 1'b0);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/event_timestamp_fifo.md
Name: event_timestamp_fifo

Overview:
- Downstream of top_pixel_hierarchy. Consumes each arbitrated pixel event word (data_out_o) and the group-release marker.
- Tags each event with a free-running timestamp and buffers it in a first-word-fall-through FIFO.
- Presents events to the readout interface with a valid/ready handshake.
- Counts events dropped on overflow.

Parameters:
- WIDTH, 10, event word width. Matches the hierarchy data_out_o width from lib_arbiter_pkg.
- TS_WIDTH, 16, timestamp counter width.
- DEPTH, 8, FIFO entries. Must be a power of 2, at least 2.
- DROP_W, 8, drop counter width.

Ports:
- clk_i  input  1  clock; all logic on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- evt_valid_i  input  1  event word present this cycle; each high cycle is one event.
- evt_data_i  input  WIDTH  event word from the hierarchy.
- grp_release_i  input  1  group release; sampled with evt_valid_i and marks the last event of a group.
- out_ready_i  input  1  consumer accepts the head entry.
- out_valid_o  output  1  head entry valid.
- out_data_o  output  WIDTH+TS_WIDTH+1  packed as {last, timestamp, event}; MSB = last.
- level_o  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_o  output  1  sticky; set when any event is dropped.
- drop_cnt_o  output  DROP_W  dropped-event count, saturating.
- clr_ovf_i  input  1  synchronous clear of overflow_o and drop_cnt_o.

Behaviour:
- Reset (asynchronous assert, takes effect immediately):
  - ts counter, write/read pointers and count go to 0.
  - out_valid_o=0, level_o=0, overflow_o=0, drop_cnt_o=0.
  - out_data_o is don't-care while out_valid_o=0.
  - A reset mid-operation discards all stored entries; nothing is presented after release.
- Timestamp:
  - ts_q increments by 1 every cycle after reset release.
  - Wraps from 2^TS_WIDTH-1 to 0 with no flag.
  - An event accepted in cycle N stores the ts_q value visible in cycle N.
- Push: push = evt_valid_i && (!full || pop).
  - Writes {grp_release_i, ts_q, evt_data_i} at wr_ptr.
  - wr_ptr advances modulo DEPTH.
- Pop: pop = out_valid_o && out_ready_i; rd_ptr advances modulo DEPTH.
- out_valid_o = (count != 0).
  - out_data_o = mem[rd_ptr], combinational from storage (FWFT).
  - Head data must stay stable while out_valid_o && !out_ready_i.
- Latency: an event pushed into an empty FIFO in cycle N gives out_valid_o=1 in cycle N+1.
  - No bypass: an empty FIFO never shows valid in the same cycle as the push.
- Count: count_next = count + push - pop. level_o = count.
- Simultaneous push+pop:
  - When full: both accepted, count stays DEPTH.
  - When empty: pop is impossible (out_valid_o=0); push only.
- Drop: evt_valid_i && full && !pop.
  - Event discarded; overflow_o set to 1.
  - drop_cnt_o increments, saturating at 2^DROP_W-1.
- clr_ovf_i:
  - Clears overflow_o and drop_cnt_o next edge.
  - If a drop occurs in the same cycle: overflow_o=1 and drop_cnt_o=1 (drop wins over clear).
- No state machine beyond pointers and count. Full/empty are derived from count, not pointer equality alone.

Test Plan:
- Reset, then evt_valid_i=1 for one cycle with evt_data_i=10'h2A5, grp_release_i=0, out_ready_i=1 -> next cycle out_valid_o=1 and out_data_o={0, ts at push, 10'h2A5}; the following cycle level_o=0.
- Push 8 events 0x001..0x008 with out_ready_i=0 -> level_o=8, overflow_o=0. Push 0x009 -> dropped, overflow_o=1, drop_cnt_o=1. Then drain with ready=1 -> reads 0x001..0x008 in order, timestamps strictly increasing by 1.
- FIFO full (8 entries), out_ready_i=1 and evt_valid_i=1 same cycle -> no drop, level_o stays 8, head advances to the next entry.
- Force 300 drops while full (DROP_W=8) -> drop_cnt_o=255 saturated. Assert clr_ovf_i with no drop -> overflow_o=0, drop_cnt_o=0. Assert clr_ovf_i together with a drop -> overflow_o=1, drop_cnt_o=1.
- Run 65540 cycles, push one event at cycle offset 65535 and one at 65537 after reset release -> stored timestamps 16'hFFFF and 16'h0001 (wrap).
- 3 entries queued, assert reset_i asynchronously between edges -> out_valid_o=0 and level_o=0 immediately; after release, no stale data appears and timestamps restart at 0.
